// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and constants for the memory controller slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] OUT_PORT_ADDR = 32'hFFFF_FFF0;
    localparam logic [31:0] IN_PORT_ADDR  = 32'hFFFF_FFF1;

    localparam int c_wait_cnt_w = 4;

endpackage
`default_nettype wire

// File: rtl/sram_1p.sv
`default_nettype none
// ============================================================================
//  Module      : sram_1p
//  Description : Single-port RAM, synchronous write, combinational read.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_1p #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    // Contents deliberately have no reset so they survive a controller reset.
    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl
//  Description : Wait-state memory controller with RAM and two MMIO ports,
//                four-phase read/write handshake toward the processor.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [31:0] iAddr,
    input  logic [31:0] iData,
    input  logic        iRead,
    input  logic        iWrite,
    output logic [31:0] oData,
    output logic        oRdy,
    output logic        oErr,
    output logic [31:0] oOutPort,
    input  logic [31:0] iInPort
);

    localparam logic [c_wait_cnt_w-1:0] c_wait_load =
        (WAIT_CYCLES == 0) ? '0 : c_wait_cnt_w'(WAIT_CYCLES - 1);

    state_t                  r_state;
    logic [c_wait_cnt_w-1:0] r_cnt;
    logic [31:0]             r_addr;
    logic [31:0]             r_data;
    logic                    r_rd;
    logic                    r_wr;
    logic [31:0]             r_rdata;
    logic                    r_rdy;
    logic                    r_err;
    logic [31:0]             r_out_port;

    logic [31:0] w_src_addr;
    logic [31:0] w_src_data;
    logic        w_src_rd;
    logic        w_src_wr;
    logic        w_hit_ram;
    logic        w_hit_out;
    logic        w_hit_in;
    logic        w_err;
    logic        w_start;
    logic        w_enter_resp;
    logic        w_ram_we;
    logic [31:0] w_ram_rdata;
    logic [31:0] w_read_val;

    // With zero wait states the commit happens on the capture edge itself,
    // so the request must come straight from the ports rather than the latch.
    always_comb begin
        w_src_addr = r_addr;
        w_src_data = r_data;
        w_src_rd   = r_rd;
        w_src_wr   = r_wr;
        if (r_state == ST_IDLE) begin
            w_src_addr = iAddr;
            w_src_data = iData;
            w_src_rd   = iRead;
            w_src_wr   = iWrite;
        end
    end

    assign w_hit_ram = (w_src_addr >> ADDR_W) == 32'd0;
    assign w_hit_out = (w_src_addr == OUT_PORT_ADDR);
    assign w_hit_in  = (w_src_addr == IN_PORT_ADDR);
    assign w_err     = (w_src_rd & w_src_wr)
                     | ~(w_hit_ram | w_hit_out | w_hit_in)
                     | (w_src_wr & w_hit_in);

    assign w_start      = (r_state == ST_IDLE) & (iRead | iWrite);
    assign w_enter_resp = ((WAIT_CYCLES == 0) & w_start)
                        | ((r_state == ST_WAIT) & (r_cnt == '0));
    assign w_ram_we     = w_enter_resp & w_src_wr & ~w_err & w_hit_ram & ~iRst;

    always_comb begin
        w_read_val = iInPort;
        if (w_hit_ram) begin
            w_read_val = w_ram_rdata;
        end else if (w_hit_out) begin
            w_read_val = r_out_port;
        end
    end

    sram_1p #(
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) u_sram (
        .i_clk   (iClk),
        .i_we    (w_ram_we),
        .i_addr  (w_src_addr[ADDR_W-1:0]),
        .i_wdata (w_src_data),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_rdata    <= '0;
            r_rdy      <= 1'b0;
            r_err      <= 1'b0;
            r_out_port <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_addr <= iAddr;
                        r_data <= iData;
                        r_rd   <= iRead;
                        r_wr   <= iWrite;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= c_wait_load;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (!iRead && !iWrite) begin
                        r_state <= ST_IDLE;
                        r_rdy   <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_enter_resp) begin
                r_rdy <= 1'b1;
                r_err <= w_err;
                if (w_src_rd) begin
                    r_rdata <= w_err ? 32'd0 : w_read_val;
                end
                if (w_src_wr && !w_err && w_hit_out) begin
                    r_out_port <= w_src_data;
                end
            end
        end
    end

    assign oData    = r_rdata;
    assign oRdy     = r_rdy;
    assign oErr     = r_err;
    assign oOutPort = r_out_port;

endmodule
`default_nettype wire
